// File: rtl/axi_ipencoder_pkg.sv
// axi_ipencoder_pkg
//   Shared constants for the IP-encoder AXI4-Lite register slice:
//   register word indices, the OKAY response code and the write/read
//   channel state encodings.
package axi_ipencoder_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_1     = 2'd1;
    localparam logic [1:0] REG_2     = 2'd2;
    localparam logic [1:0] REG_3     = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/axi_ipencoder_wstrb_merge.sv
// axi_ipencoder_wstrb_merge
//   Combinational byte merge of the current register word with new write data.
//   Ports: old_i    current register contents
//          wdata_i  incoming write data
//          wstrb_i  byte lane enables
//          merged_o value to store
//   Build option: IPENC_REGS_WSTRB_EN selects per-byte updates; without it
//   the whole word is replaced and the strobes are ignored.
module axi_ipencoder_wstrb_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] merged_o
);

`ifdef IPENC_REGS_WSTRB_EN
    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) begin
                merged_o[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end
`else
    logic [35:0] unused_merge;
    assign unused_merge = {old_i, wstrb_i};
    assign merged_o     = wdata_i;
`endif

endmodule

// File: rtl/axi_ipencoder_s00_regs.sv
// axi_ipencoder_s00_regs
//   AXI4-Lite slave with four 32-bit registers feeding the IP-encoder core.
//   Ports: ACLK/ARESET (sync, active-high), AXI4-Lite AW/W/B/AR/R channels,
//          reg_o   = {reg3, reg2, reg1, reg0}
//          start_o = one-cycle pulse after a write of reg0 bit0 = 1
//   Build option: IPENC_REGS_WSTRB_EN enables byte-strobe writes.
//
//   write state | meaning
//   W_IDLE      | waiting for AW and/or W
//   W_HAVE_AW   | address latched, waiting for data
//   W_HAVE_W    | data latched, waiting for address
//   W_RESP      | BVALID up, waiting for BREADY
//
//   read state  | meaning
//   R_IDLE      | ARREADY up
//   R_DATA      | RVALID up, RDATA held until RREADY
module axi_ipencoder_s00_regs
    import axi_ipencoder_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
    output logic                              start_o
);

    wstate_e     wstate_q, wstate_d;
    rstate_e     rstate_q, rstate_d;
    logic        live_q;
    logic [1:0]  awidx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] regs_q [4];
    logic        start_q, start_d;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data, merged;
    logic [3:0]  wr_strb;
    logic        lane0_en;

    logic [9:0]  unused_axi;
    assign unused_axi = {S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // live_q keeps every ready low during reset and for the reset edge itself,
    // so readies rise only in the first cycle after ARESET has been seen low.
    assign S_AXI_AWREADY = live_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_W));
    assign S_AXI_WREADY  = live_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_AW));
    assign S_AXI_BVALID  = (wstate_q == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = live_q && (rstate_q == R_IDLE);
    assign S_AXI_RVALID  = (rstate_q == R_DATA);
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        wstate_d = wstate_q;
        wr_en    = 1'b0;
        wr_idx   = awidx_q;
        wr_data  = wdata_q;
        wr_strb  = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en    = 1'b1;
                    wr_idx   = S_AXI_AWADDR[3:2];
                    wr_data  = S_AXI_WDATA;
                    wr_strb  = S_AXI_WSTRB;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    wr_en    = 1'b1;
                    wr_data  = S_AXI_WDATA;
                    wr_strb  = S_AXI_WSTRB;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    wr_en    = 1'b1;
                    wr_idx   = S_AXI_AWADDR[3:2];
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    axi_ipencoder_wstrb_merge u_merge (
        .old_i    (regs_q[wr_idx]),
        .wdata_i  (wr_data),
        .wstrb_i  (wr_strb),
        .merged_o (merged)
    );

`ifdef IPENC_REGS_WSTRB_EN
    assign lane0_en = wr_strb[0];
`else
    assign lane0_en = 1'b1;
`endif

    assign start_d = wr_en && (wr_idx == REG_CTRL) && wr_data[0] && lane0_en;

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs)        rstate_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            live_q   <= 1'b0;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            live_q   <= 1'b1;
            if (aw_hs) awidx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // reg0 bit0 is visible for exactly the cycle start_o is high, then clears.
    // A write landing on the clearing edge takes priority.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            start_q <= 1'b0;
        end else begin
            if (start_q) regs_q[REG_CTRL][0] <= 1'b0;
            if (wr_en)   regs_q[wr_idx]      <= merged;
            start_q <= start_d;
        end
    end

    // RDATA samples regs_q before this edge's write lands: pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) rdata_q <= regs_q[S_AXI_ARADDR[3:2]];
        end
    end

    assign reg_o   = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign start_o = start_q;

endmodule

// File: tb/tb_axi_ipencoder_s00_regs.sv
module tb_axi_ipencoder_s00_regs;

    localparam int TMO = 100;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [3:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [3:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] reg_o;
    logic         start_o;

    always #5 ACLK = ~ACLK;

    axi_ipencoder_s00_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_o(reg_o), .start_o(start_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // transaction-level model
    logic [31:0] m_regs [4];
    bit          m_known = 0, m_live = 0;
    bit          m_have_aw = 0, m_have_w = 0, m_bpend = 0, m_rpend = 0, m_start = 0;
    logic [1:0]  m_awidx = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          p_aw = 0, p_w = 0, p_ar = 0, p_b = 0, p_r = 0;
    int          aw_hs_cyc = 0, b_hs_cyc = 0, bv_rise_cyc = 0, bv_cnt = 0, start_cnt = 0;
    bit          bv_prev = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
`ifdef IPENC_REGS_WSTRB_EN
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    function automatic bit lane0(input logic [3:0] s);
`ifdef IPENC_REGS_WSTRB_EN
        return s[0];
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge ACLK) cyc <= cyc + 1;

    // Compare DUT outputs to the model, then advance the model across the
    // coming edge using the inputs currently applied.
    always @(negedge ACLK) begin : model
        bit ea, ew, ear, ha, hd;
        ea  = m_live && !m_have_aw && !m_bpend;
        ew  = m_live && !m_have_w  && !m_bpend;
        ear = m_live && !m_rpend;
        if (m_known) begin
            chk("awready", 128'(S_AXI_AWREADY), 128'(ea));
            chk("wready",  128'(S_AXI_WREADY),  128'(ew));
            chk("arready", 128'(S_AXI_ARREADY), 128'(ear));
            chk("bvalid",  128'(S_AXI_BVALID),  128'(m_bpend));
            chk("bresp",   128'(S_AXI_BRESP),   128'(0));
            chk("rvalid",  128'(S_AXI_RVALID),  128'(m_rpend));
            chk("rresp",   128'(S_AXI_RRESP),   128'(0));
            chk("rdata",   128'(S_AXI_RDATA),   128'(m_rdata));
            chk("reg_o",   reg_o, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            chk("start_o", 128'(start_o),       128'(m_start));
            if (S_AXI_BVALID && !bv_prev) bv_rise_cyc = cyc;
            bv_prev = S_AXI_BVALID;
            if (S_AXI_BVALID) bv_cnt++;
            if (start_o) start_cnt++;
        end
        if (ARESET) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_live = 0; m_have_aw = 0; m_have_w = 0; m_bpend = 0; m_rpend = 0;
            m_start = 0; m_rdata = '0; m_known = 1;
            p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
        end else if (m_known) begin
            p_aw = S_AXI_AWVALID && ea;
            p_w  = S_AXI_WVALID && ew;
            p_ar = S_AXI_ARVALID && ear;
            p_b  = m_bpend && S_AXI_BREADY;
            p_r  = m_rpend && S_AXI_RREADY;
            if (p_aw) aw_hs_cyc = cyc;
            if (p_b)  b_hs_cyc = cyc;
            if (p_ar) begin
                m_rdata = m_regs[S_AXI_ARADDR[3:2]];
                m_rpend = 1;
            end else if (p_r) begin
                m_rpend = 0;
            end
            if (m_start) m_regs[0][0] = 1'b0;
            m_start = 0;
            if (p_b) begin
                m_bpend = 0;
            end else if (!m_bpend) begin
                ha = m_have_aw || p_aw;
                hd = m_have_w || p_w;
                if (p_aw) m_awidx = S_AXI_AWADDR[3:2];
                if (p_w) begin
                    m_wdata = S_AXI_WDATA;
                    m_wstrb = S_AXI_WSTRB;
                end
                if (ha && hd) begin
                    m_regs[m_awidx] = mmerge(m_regs[m_awidx], m_wdata, m_wstrb);
                    m_start = (m_awidx == 2'd0) && m_wdata[0] && lane0(m_wstrb);
                    m_bpend = 1; m_have_aw = 0; m_have_w = 0;
                end else begin
                    m_have_aw = ha; m_have_w = hd;
                end
            end
            m_live = 1;
        end
    end

    task automatic timeout(input string nm);
        n_vec++; n_err++;
        $display("FAIL timeout_%s: no handshake within %0d cycles", nm, TMO);
    endtask

    task automatic wait_aw();
        for (int n = 0; ; n++) begin
            @(posedge ACLK); #1;
            if (p_aw) break;
            if (n >= TMO) begin timeout("aw"); break; end
        end
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] a, input int dly);
        repeat (dly) @(posedge ACLK);
        #1; S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        wait_aw();
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) @(posedge ACLK);
        #1; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        for (int n = 0; ; n++) begin
            @(posedge ACLK); #1;
            if (p_w) break;
            if (n >= TMO) begin timeout("w"); break; end
        end
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic recv_b(input int dly);
        for (int n = 0; !m_bpend; n++) begin
            if (n >= TMO) begin timeout("bvalid"); return; end
            @(posedge ACLK); #1;
        end
        repeat (dly) @(posedge ACLK);
        #1; S_AXI_BREADY = 1'b1;
        for (int n = 0; ; n++) begin
            @(posedge ACLK); #1;
            if (p_b) break;
            if (n >= TMO) begin timeout("b"); break; end
        end
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        fork
            send_aw(a, awd);
            send_w(d, s, wd);
            recv_b(bd);
        join
    endtask

    task automatic do_read(input logic [3:0] a, input int ard, input int rd, output logic [31:0] data);
        data = '0;
        repeat (ard) @(posedge ACLK);
        #1; S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int n = 0; ; n++) begin
            @(posedge ACLK); #1;
            if (p_ar) break;
            if (n >= TMO) begin timeout("ar"); S_AXI_ARVALID = 1'b0; return; end
        end
        S_AXI_ARVALID = 1'b0;
        repeat (rd) @(posedge ACLK);
        #1; S_AXI_RREADY = 1'b1;
        for (int n = 0; ; n++) begin
            @(posedge ACLK); #1;
            if (p_r) break;
            if (n >= TMO) begin timeout("r"); break; end
        end
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic do_reset(input int n);
        #1; ARESET = 1'b1;
        repeat (n) @(posedge ACLK);
        #1; ARESET = 1'b0;
        @(posedge ACLK); #1;
    endtask

    initial begin : stim
        logic [31:0] d0, d1, d2, d3;
        int b_first;
        repeat (3) @(posedge ACLK);
        #1; ARESET = 1'b0;
        @(posedge ACLK); #1;

        // four writes; reg0 is read back in the single cycle its bit0 is still set
        start_cnt = 0;
        fork
            do_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
            do_read(4'h0, 1, 0, d0);
        join
        do_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'h3, 4'hF, 1, 0, 2);
        do_write(4'hC, 32'h4, 4'hF, 0, 2, 1);
        do_read(4'h4, 0, 0, d1);
        do_read(4'h9, 0, 2, d2);
        do_read(4'hF, 1, 0, d3);
        chk("seq_rd0", 128'(d0), 128'h1);
        chk("seq_rd1", 128'(d1), 128'h2);
        chk("seq_rd2", 128'(d2), 128'h3);
        chk("seq_rd3", 128'(d3), 128'h4);
        chk("seq_reg_o", reg_o, 128'h00000004_00000003_00000002_00000000);
        chk("seq_start_pulses", 128'(start_cnt), 128'd1);

        // W leads AW by three cycles
        fork
            send_w(32'hDEADBEEF, 4'hF, 0);
            send_aw(4'h4, 3);
            recv_b(0);
        join
        chk("w_first_b_latency", 128'(bv_rise_cyc - aw_hs_cyc), 128'd1);
        do_read(4'h4, 0, 0, d0);
        chk("w_first_rd", 128'(d0), 128'hDEADBEEF);

        // BREADY stalled; a second AW waits for the B handshake
        fork
            do_write(4'h8, 32'h55, 4'hF, 0, 0, 5);
            begin
                for (int n = 0; !m_bpend && n < TMO; n++) begin @(posedge ACLK); #1; end
                @(posedge ACLK); #2;
                S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
            end
        join
        b_first = b_hs_cyc;
        fork
            wait_aw();
            send_w(32'h66, 4'hF, 2);
        join
        chk("aw_after_b", 128'(aw_hs_cyc > b_first), 128'd1);
        recv_b(0);
        do_read(4'h8, 0, 0, d0);
        do_read(4'hC, 0, 0, d1);
        chk("stall_rd8", 128'(d0), 128'h55);
        chk("stall_rdC", 128'(d1), 128'h66);

        // byte strobes
        do_write(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        do_read(4'h4, 0, 0, d0);
`ifdef IPENC_REGS_WSTRB_EN
        chk("wstrb_rd", 128'(d0), 128'h11BB33DD);
`else
        chk("wstrb_rd", 128'(d0), 128'hAABBCCDD);
`endif

        // randomized traffic, sometimes with a concurrent read
        for (int i = 0; i < 60; i++) begin
            logic [3:0] a, ra;
            logic [31:0] d;
            logic [3:0] s;
            bit rd_en;
            a = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            rd_en = ($urandom_range(0, 1) == 1);
            fork
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                begin
                    if (rd_en) do_read(ra, $urandom_range(0, 3), $urandom_range(0, 2), d0);
                end
            join
        end

        // reset while an address is held with no data
        do_write(4'h0, 32'hFFFF_FFFE, 4'hF, 0, 0, 0);
        #1; S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        wait_aw();
        chk("have_aw_before_reset", 128'(m_have_aw), 128'd1);
        do_reset(2);
        bv_cnt = 0;
        repeat (10) @(posedge ACLK);
        #1;
        chk("no_b_after_reset", 128'(bv_cnt), 128'd0);
        do_read(4'h0, 0, 0, d0);
        do_read(4'h4, 0, 0, d1);
        do_read(4'h8, 0, 0, d2);
        do_read(4'hC, 0, 0, d3);
        chk("rst_rd0", 128'(d0), 128'h0);
        chk("rst_rd1", 128'(d1), 128'h0);
        chk("rst_rd2", 128'(d2), 128'h0);
        chk("rst_rd3", 128'(d3), 128'h0);

        repeat (3) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_ipencoder_s00_regs.md
AXI_IPENCODER_S00_REGS -- requirements
Module: axi_ipencoder_s00_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 word registers.
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte lanes.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- reg_o  out  128  registers 0..3 packed, reg0 in [31:0], to encoder core.
- start_o  out  1  one-cycle pulse to encoder core.

Function
REQ-004 SHALL decode word index from ADDR[3:2]; ADDR[1:0] ignored; all four registers read/write.
REQ-005 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-006 W_IDLE: AWREADY=WREADY=1; AW and W both handshaken in the same cycle -> register written that edge, go W_RESP; only AW -> W_HAVE_AW; only W -> W_HAVE_W.
REQ-007 W_HAVE_AW: AWREADY=0, WREADY=1; W handshake writes the latched address, go W_RESP. W_HAVE_W symmetric, with the address arriving last.
REQ-008 W_RESP: BVALID=1, BRESP=2'b00; AWREADY=WREADY=0; BVALID held until BREADY, then W_IDLE. Minimum AW-to-BVALID latency 1 cycle.
REQ-009 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1, RRESP=2'b00); AR handshake registers RDATA, go R_DATA; RDATA/RVALID stable until RREADY, then R_IDLE.
REQ-010 Read and write to the same register on the same edge: RDATA SHALL return the pre-write value.
REQ-011 A write to reg0 with WDATA[0]=1 (lane 0 enabled) SHALL pulse start_o high exactly the next cycle; reg0 bit0 SHALL self-clear on the same edge as the pulse.
REQ-012 Back-to-back writes: the next AW/W SHALL NOT be accepted before BVALID&&BREADY completes; no outstanding transactions beyond one per channel.

Reset
REQ-013 While ARESET=1, at each edge: registers=0, start_o=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, both FSMs idle.
REQ-014 ARESET asserted mid-transaction SHALL abandon it; no B or R response is issued after release. AWREADY/WREADY/ARREADY rise the first cycle after release.

Configuration
REQ-015 Macro IPENC_REGS_WSTRB_EN defined: only bytes with WSTRB bit set update. Undefined: WSTRB ignored, full 32-bit word written.

Structure
REQ-016 Package axi_ipencoder_pkg SHALL hold the register index constants (REG_CTRL=0..REG_3=3), the OKAY response constant, and the write/read FSM state enums.
REQ-017 Sub-module axi_ipencoder_wstrb_merge (combinational byte merge of old data, WDATA, WSTRB) SHALL be instantiated once.

Verification
REQ-018 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1,0x2,0x3,0x4, RRESP=0, reg_o=0x00000004_00000003_00000002_00000000 (reg0 bit0 self-cleared), start_o one pulse.
REQ-019 W presented 3 cycles before AW (addr 0x4, 0xDEADBEEF) -> single write, BVALID 1 cycle after AW handshake, read 0x4 = 0xDEADBEEF.
REQ-020 BREADY held low 5 cycles -> BVALID/BRESP stable; second AW not accepted until B handshake.
REQ-021 With IPENC_REGS_WSTRB_EN: reg1=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x11BB33DD. Without the macro: read 0xAABBCCDD.
REQ-022 ARESET pulsed while in W_HAVE_AW -> no BVALID ever; all registers read 0.
